// File: rtl/time_digits_p_if.sv
`default_nettype none
// ============================================================================
// Module   : time_digits_p_if
// Purpose  : Advance/load/display bundle for the time_digits_p BCD clock.
//            master = the side driving requests, slave = the clock core.
// Revision : 1.0 - initial release
// ============================================================================
interface time_digits_p_if;
  // requests
  logic       inc_i;
  logic       mode_12h_i;
  logic       load_i;
  logic [1:0] hour_h_load_i;
  logic [3:0] hour_l_load_i;
  logic [2:0] minute_h_load_i;
  logic [3:0] minute_l_load_i;
  logic [2:0] second_h_load_i;
  logic [3:0] second_l_load_i;
  // displayed time and status
  logic [1:0] hour_h_digit_o;
  logic [3:0] hour_l_digit_o;
  logic [2:0] min_h_digit_o;
  logic [3:0] min_l_digit_o;
  logic [2:0] sec_h_digit_o;
  logic [3:0] sec_l_digit_o;
  logic       pm_o;
  logic       rollover_o;
  logic       load_err_o;

  modport master (
    output inc_i, mode_12h_i, load_i,
    output hour_h_load_i, hour_l_load_i, minute_h_load_i,
    output minute_l_load_i, second_h_load_i, second_l_load_i,
    input  hour_h_digit_o, hour_l_digit_o, min_h_digit_o,
    input  min_l_digit_o, sec_h_digit_o, sec_l_digit_o,
    input  pm_o, rollover_o, load_err_o
  );

  modport slave (
    input  inc_i, mode_12h_i, load_i,
    input  hour_h_load_i, hour_l_load_i, minute_h_load_i,
    input  minute_l_load_i, second_h_load_i, second_l_load_i,
    output hour_h_digit_o, hour_l_digit_o, min_h_digit_o,
    output min_l_digit_o, sec_h_digit_o, sec_l_digit_o,
    output pm_o, rollover_o, load_err_o
  );
endinterface
`default_nettype wire

// File: rtl/time_digits_p.sv
`default_nettype none
// ============================================================================
// Module   : time_digits_p
// Purpose  : 24-hour BCD time-of-day counter with prescaled advance, checked
//            parallel load and optional 12-hour display conversion.
// Revision : 1.0 - initial release
// ============================================================================
module time_digits_p #(
  parameter int unsigned TICK_DIV  = 1,
  parameter bit          HOUR12_EN = 1'b1
) (
  input logic            clk_i,
  input logic            rst_i,
  time_digits_p_if.slave bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // time state (always 24-hour internally)
  logic [1:0] hour_h_q, hour_h_d;
  logic [3:0] hour_l_q, hour_l_d;
  logic [2:0] min_h_q,  min_h_d;
  logic [3:0] min_l_q,  min_l_d;
  logic [2:0] sec_h_q,  sec_h_d;
  logic [3:0] sec_l_q,  sec_l_d;
  logic       rollover_q, rollover_d;
  logic       load_err_q, load_err_d;

  logic load_valid;
  logic load_ok;
  logic accept;
  logic tick;
  logic at_day_end;

  // A load (valid or not) always swallows inc_i of the same cycle.
  assign accept  = bus.inc_i & ~bus.load_i;
  assign load_ok = bus.load_i & load_valid;

  // Range check of the load fields; hour must form 00..23.
  always_comb begin
    load_valid = 1'b1;
    if (bus.hour_h_load_i > 2'd2)                             load_valid = 1'b0;
    if (bus.hour_l_load_i > 4'd9)                             load_valid = 1'b0;
    if (bus.hour_h_load_i == 2'd2 && bus.hour_l_load_i > 4'd3) load_valid = 1'b0;
    if (bus.minute_h_load_i > 3'd5)                           load_valid = 1'b0;
    if (bus.minute_l_load_i > 4'd9)                           load_valid = 1'b0;
    if (bus.second_h_load_i > 3'd5)                           load_valid = 1'b0;
    if (bus.second_l_load_i > 4'd9)                           load_valid = 1'b0;
  end

  generate
    if (TICK_DIV > 1) begin : g_presc
      localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
      logic [PRESC_W-1:0] presc_q, presc_d;

      // Prescaler: cleared by a valid load, wraps on the terminal count.
      always_comb begin
        presc_d = presc_q;
        if (load_ok) begin
          presc_d = '0;
        end else if (accept) begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        end
      end

      // Prescaler register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) presc_q <= '0;
        else       presc_q <= presc_d;
      end

      assign tick = accept & (presc_q == PRESC_MAX);
    end else begin : g_no_presc
      assign tick = accept;
    end
  endgenerate

  assign at_day_end = (hour_h_q == 2'd2) && (hour_l_q == 4'd3) &&
                      (min_h_q == 3'd5) && (min_l_q == 4'd9) &&
                      (sec_h_q == 3'd5) && (sec_l_q == 4'd9);

  // Next time: load has priority, otherwise a full carry chain in one edge.
  always_comb begin
    hour_h_d   = hour_h_q;
    hour_l_d   = hour_l_q;
    min_h_d    = min_h_q;
    min_l_d    = min_l_q;
    sec_h_d    = sec_h_q;
    sec_l_d    = sec_l_q;
    rollover_d = 1'b0;
    load_err_d = bus.load_i & ~load_valid;
    if (load_ok) begin
      hour_h_d = bus.hour_h_load_i;
      hour_l_d = bus.hour_l_load_i;
      min_h_d  = bus.minute_h_load_i;
      min_l_d  = bus.minute_l_load_i;
      sec_h_d  = bus.second_h_load_i;
      sec_l_d  = bus.second_l_load_i;
    end else if (tick) begin
      rollover_d = at_day_end;
      if (sec_l_q != 4'd9) begin
        sec_l_d = sec_l_q + 4'd1;
      end else begin
        sec_l_d = 4'd0;
        if (sec_h_q != 3'd5) begin
          sec_h_d = sec_h_q + 3'd1;
        end else begin
          sec_h_d = 3'd0;
          if (min_l_q != 4'd9) begin
            min_l_d = min_l_q + 4'd1;
          end else begin
            min_l_d = 4'd0;
            if (min_h_q != 3'd5) begin
              min_h_d = min_h_q + 3'd1;
            end else begin
              min_h_d = 3'd0;
              if (hour_h_q == 2'd2 && hour_l_q == 4'd3) begin
                hour_h_d = 2'd0;
                hour_l_d = 4'd0;
              end else if (hour_l_q == 4'd9) begin
                hour_l_d = 4'd0;
                hour_h_d = hour_h_q + 2'd1;
              end else begin
                hour_l_d = hour_l_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Time and status pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hour_h_q   <= 2'd0;
      hour_l_q   <= 4'd0;
      min_h_q    <= 3'd0;
      min_l_q    <= 4'd0;
      sec_h_q    <= 3'd0;
      sec_l_q    <= 4'd0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hour_h_q   <= hour_h_d;
      hour_l_q   <= hour_l_d;
      min_h_q    <= min_h_d;
      min_l_q    <= min_l_d;
      sec_h_q    <= sec_h_d;
      sec_l_q    <= sec_l_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  logic [4:0] hour_bin;
  logic [4:0] disp_bin;
  logic [4:0] disp_m10;
  logic [1:0] disp_h;
  logic [3:0] disp_l;

  // Hour display: 24-hour digits pass through, 12-hour goes via binary.
  always_comb begin
    hour_bin = (5'(hour_h_q) * 5'd10) + 5'(hour_l_q);
    disp_bin = hour_bin;
    if (hour_bin == 5'd0)       disp_bin = 5'd12;
    else if (hour_bin > 5'd12)  disp_bin = hour_bin - 5'd12;
    disp_m10 = disp_bin - 5'd10;
    disp_h   = hour_h_q;
    disp_l   = hour_l_q;
    if (HOUR12_EN && bus.mode_12h_i) begin
      if (disp_bin >= 5'd10) begin
        disp_h = 2'd1;
        disp_l = disp_m10[3:0];
      end else begin
        disp_h = 2'd0;
        disp_l = disp_bin[3:0];
      end
    end
  end

  assign bus.hour_h_digit_o = disp_h;
  assign bus.hour_l_digit_o = disp_l;
  assign bus.min_h_digit_o  = min_h_q;
  assign bus.min_l_digit_o  = min_l_q;
  assign bus.sec_h_digit_o  = sec_h_q;
  assign bus.sec_l_digit_o  = sec_l_q;
  assign bus.pm_o           = (hour_bin >= 5'd12);
  assign bus.rollover_o     = rollover_q;
  assign bus.load_err_o     = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_time_digits_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_digits_p
// Purpose  : Directed bench for time_digits_p (TICK_DIV=1 and TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_digits_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inc = 1'b0, mode = 1'b0, load = 1'b0;
  logic [19:0] ld = '0;

  time_digits_p_if bus1 ();
  time_digits_p_if bus4 ();

  assign bus1.inc_i = inc;  assign bus1.mode_12h_i = mode;  assign bus1.load_i = load;
  assign bus4.inc_i = inc;  assign bus4.mode_12h_i = mode;  assign bus4.load_i = load;
  assign {bus1.hour_h_load_i, bus1.hour_l_load_i, bus1.minute_h_load_i,
          bus1.minute_l_load_i, bus1.second_h_load_i, bus1.second_l_load_i} = ld;
  assign {bus4.hour_h_load_i, bus4.hour_l_load_i, bus4.minute_h_load_i,
          bus4.minute_l_load_i, bus4.second_h_load_i, bus4.second_l_load_i} = ld;

  time_digits_p #(.TICK_DIV(1), .HOUR12_EN(1'b1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  time_digits_p #(.TICK_DIV(4), .HOUR12_EN(1'b1)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  // observed word: hh(2) hl(4) mh(3) ml(4) sh(3) sl(4) pm roll err
  wire [22:0] obs1 = {bus1.hour_h_digit_o, bus1.hour_l_digit_o, bus1.min_h_digit_o,
                      bus1.min_l_digit_o, bus1.sec_h_digit_o, bus1.sec_l_digit_o,
                      bus1.pm_o, bus1.rollover_o, bus1.load_err_o};
  wire [22:0] obs4 = {bus4.hour_h_digit_o, bus4.hour_l_digit_o, bus4.min_h_digit_o,
                      bus4.min_l_digit_o, bus4.sec_h_digit_o, bus4.sec_l_digit_o,
                      bus4.pm_o, bus4.rollover_o, bus4.load_err_o};

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [19:0] raw(input int hh, hl, mh, ml, sh, sl);
    return {2'(hh), 4'(hl), 3'(mh), 4'(ml), 3'(sh), 4'(sl)};
  endfunction

  function automatic logic [19:0] tm(input int h, m, s);
    return raw(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
  endfunction

  function automatic logic [22:0] ex(input logic [19:0] d, input logic pm, roll, err);
    return {d, pm, roll, err};
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inc = 1'b0; load = 1'b0; ld = '0;
  endtask

  typedef struct {
    logic        load;
    logic        inc;
    logic        mode;
    logic [19:0] ld;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, input logic i, input logic m,
                     input logic [19:0] d, input logic [22:0] e);
    vec_t v;
    v.load = l; v.inc = i; v.mode = m; v.ld = d; v.exp = e;
    vecs.push_back(v);
  endtask

  int roll_seen;

  initial begin
    // table of single-cycle vectors applied to the TICK_DIV=1 instance
    add(1, 1, 0, tm(5, 6, 7),            ex(tm(5, 6, 7),   0, 0, 0));
    add(1, 1, 0, raw(2, 4, 0, 0, 0, 0),  ex(tm(5, 6, 7),   0, 0, 1));
    add(0, 1, 0, '0,                     ex(tm(5, 6, 8),   0, 0, 0));
    add(1, 0, 0, tm(9, 59, 59),          ex(tm(9, 59, 59), 0, 0, 0));
    add(0, 1, 0, '0,                     ex(tm(10, 0, 0),  0, 0, 0));
    add(1, 0, 0, tm(19, 59, 59),         ex(tm(19, 59, 59), 1, 0, 0));
    add(0, 1, 1, '0,                     ex(tm(8, 0, 0),   1, 0, 0));
    add(1, 0, 1, tm(0, 30, 0),           ex(tm(12, 30, 0), 0, 0, 0));
    add(1, 0, 1, tm(13, 45, 0),          ex(tm(1, 45, 0),  1, 0, 0));
    add(1, 0, 1, tm(12, 0, 0),           ex(tm(12, 0, 0),  1, 0, 0));
    add(0, 0, 0, '0,                     ex(tm(12, 0, 0),  1, 0, 0));
    add(1, 0, 0, tm(23, 59, 59),         ex(tm(23, 59, 59), 1, 0, 0));
    add(0, 1, 0, '0,                     ex(tm(0, 0, 0),   0, 1, 0));
    add(0, 0, 0, '0,                     ex(tm(0, 0, 0),   0, 0, 0));
    add(1, 1, 0, tm(0, 0, 0),            ex(tm(0, 0, 0),   0, 0, 0));
    add(1, 1, 0, raw(0, 0, 6, 0, 0, 0),  ex(tm(0, 0, 0),   0, 0, 1));
    add(1, 1, 0, raw(0, 10, 0, 0, 0, 0), ex(tm(0, 0, 0),   0, 0, 1));
    add(1, 1, 0, raw(0, 0, 0, 10, 0, 0), ex(tm(0, 0, 0),   0, 0, 1));
    add(1, 1, 0, raw(0, 0, 0, 0, 6, 0),  ex(tm(0, 0, 0),   0, 0, 1));
    add(1, 1, 0, raw(0, 0, 0, 0, 0, 10), ex(tm(0, 0, 0),   0, 0, 1));
    add(1, 1, 0, raw(3, 0, 0, 0, 0, 0),  ex(tm(0, 0, 0),   0, 0, 1));
    add(0, 0, 0, '0,                     ex(tm(0, 0, 0),   0, 0, 0));
    add(1, 0, 1, tm(23, 0, 0),           ex(tm(11, 0, 0),  1, 0, 0));
    add(1, 0, 1, tm(11, 59, 59),         ex(tm(11, 59, 59), 0, 0, 0));
    add(0, 1, 1, '0,                     ex(tm(12, 0, 0),  1, 0, 0));
    add(1, 0, 1, tm(1, 0, 0),            ex(tm(1, 0, 0),   0, 0, 0));
    add(0, 0, 0, '0,                     ex(tm(1, 0, 0),   0, 0, 0));

    // reset held with active requests
    rst = 1'b1; inc = 1'b1; load = 1'b1; ld = tm(7, 7, 7);
    step(); step();
    chk("reset_24h_dut1", obs1, ex(tm(0, 0, 0), 0, 0, 0));
    chk("reset_24h_dut4", obs4, ex(tm(0, 0, 0), 0, 0, 0));
    mode = 1'b1; #1;
    chk("reset_12h_dut1", obs1, ex(tm(12, 0, 0), 0, 0, 0));
    mode = 1'b0;
    idle_inputs();
    rst = 1'b0;

    // 61 advances from midnight
    roll_seen = 0;
    inc = 1'b1;
    for (int i = 0; i < 61; i++) begin
      step();
      if (bus1.rollover_o) roll_seen++;
    end
    inc = 1'b0;
    step();
    if (bus1.rollover_o) roll_seen++;
    chk("count61", obs1, ex(tm(0, 1, 1), 0, 0, 0));
    chk("count61_no_rollover", 23'(roll_seen), 23'd0);

    // table
    for (int k = 0; k < vecs.size(); k++) begin
      load = vecs[k].load; inc = vecs[k].inc; mode = vecs[k].mode; ld = vecs[k].ld;
      step();
      chk($sformatf("vec%0d", k), obs1, vecs[k].exp);
    end
    idle_inputs(); mode = 1'b0;

    // prescaler: partial count discarded by a valid load (TICK_DIV=4)
    #3 rst = 1'b1; #1 rst = 1'b0;
    inc = 1'b1;
    repeat (3) step();
    inc = 1'b0; load = 1'b1; ld = tm(10, 0, 0);
    step();
    load = 1'b0; inc = 1'b1;
    repeat (3) step();
    chk("presc_after_load_3", obs4, ex(tm(10, 0, 0), 0, 0, 0));
    step();
    chk("presc_after_load_4", obs4, ex(tm(10, 0, 1), 0, 0, 0));
    inc = 1'b0;

    // prescaler: invalid load keeps partial count
    inc = 1'b1; repeat (2) step();
    inc = 1'b0; load = 1'b1; ld = raw(2, 4, 0, 0, 0, 0);
    step();
    chk("presc_bad_load", obs4, ex(tm(10, 0, 1), 0, 0, 1));
    load = 1'b0; inc = 1'b1;
    step();
    chk("presc_bad_load_3rd", obs4, ex(tm(10, 0, 1), 0, 0, 0));
    step();
    chk("presc_bad_load_4th", obs4, ex(tm(10, 0, 2), 0, 0, 0));

    // prescaler: reset mid-count discards partial count
    repeat (2) step();
    #3 rst = 1'b1; #1 rst = 1'b0;
    repeat (3) step();
    chk("presc_reset_3", obs4, ex(tm(0, 0, 0), 0, 0, 0));
    step();
    chk("presc_reset_4", obs4, ex(tm(0, 0, 1), 0, 0, 0));
    inc = 1'b0;

    // asynchronous reset between edges
    load = 1'b1; ld = tm(14, 22, 33);
    step();
    load = 1'b0;
    chk("async_pre", obs1, ex(tm(14, 22, 33), 1, 0, 0));
    #3 rst = 1'b1;
    #1;
    chk("async_immediate", obs1, ex(tm(0, 0, 0), 0, 0, 0));
    inc = 1'b1; load = 1'b1;
    step(); step();
    chk("async_held", obs1, ex(tm(0, 0, 0), 0, 0, 0));
    idle_inputs();
    rst = 1'b0;
    step();
    chk("async_released", obs1, ex(tm(0, 0, 0), 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_digits_p.md
TIME_DIGITS_P -- requirements
Module: time_digits_p

Interface
REQ-001 Parameter TICK_DIV, default 1, number of accepted inc_i pulses per seconds increment (legal 1..65535).
REQ-002 Parameter HOUR12_EN, default 1: 1 = 12-hour display mode available; 0 = mode_12h_i ignored, 24-hour display only.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 inc_i  input  1  single-cycle advance request, sampled each clk_i edge.
REQ-006 mode_12h_i  input  1  display format select (1 = 12-hour), combinational effect on hour outputs and pm_o only.
REQ-007 load_i  input  1  load request for the six load fields.
REQ-008 hour_h_load_i 2, hour_l_load_i 4, minute_h_load_i 3, minute_l_load_i 4, second_h_load_i 3, second_l_load_i 4  inputs  load value, BCD, always 24-hour format.
REQ-009 hour_h_digit_o 2, hour_l_digit_o 4, min_h_digit_o 3, min_l_digit_o 4, sec_h_digit_o 3, sec_l_digit_o 4  outputs  displayed time, BCD.
REQ-010 pm_o  output  1  high when internal hour is 12..23, in either display mode.
REQ-011 rollover_o  output  1  one-cycle registered pulse on day wrap.
REQ-012 load_err_o  output  1  one-cycle registered pulse on rejected load.

Function
REQ-013 Internal state: 24-hour BCD counter (hh 00..23, mm 00..59, ss 00..59) plus prescaler of ceil(log2(TICK_DIV)) bits (none when TICK_DIV = 1).
REQ-014 Each cycle with inc_i=1 and load_i=0, the prescaler increments; when it equals TICK_DIV-1 it clears to 0 and the time advances by one second in the same edge (TICK_DIV=1: every inc_i advances).
REQ-015 Second advance: sec_l 9->0 carries to sec_h; sec_h 5->0 carries to min_l; min_l 9->0 carries to min_h; min_h 5->0 carries to hour; all carries resolve in one clock edge (no ripple latency).
REQ-016 Hour advance: hour_l 9->0 with hour_h+1; hour 23->00 clears hour_h and hour_l.
REQ-017 Advance from 23:59:59 gives 00:00:00 and asserts rollover_o for exactly the following cycle.
REQ-018 Load validity: hh <= 23 and each BCD field within range (hour_l <= 9, minute_h <= 5, minute_l <= 9, second_h <= 5, second_l <= 9).
REQ-019 load_i=1 with valid fields: time takes load values at the edge, prescaler clears to 0, inc_i in the same cycle is discarded.
REQ-020 load_i=1 with invalid fields: time and prescaler unchanged, inc_i in the same cycle discarded, load_err_o high for exactly the following cycle.
REQ-021 Load never asserts rollover_o, including a load of 00:00:00.
REQ-022 Display, 24-hour mode (mode_12h_i=0 or HOUR12_EN=0): hour outputs equal internal hour.
REQ-023 Display, 12-hour mode: internal 00 -> 12, 01..12 -> unchanged, 13..23 -> 01..11; BCD-correct (e.g. 20 -> hour_h=0, hour_l=8); minute/second outputs unaffected.
REQ-024 Toggling mode_12h_i never modifies internal state or prescaler.
REQ-025 Internal time never leaves legal range; no input sequence yields non-BCD digits.

Reset
REQ-026 rst_i high asynchronously forces time 00:00:00, prescaler 0, rollover_o 0, load_err_o 0; held while rst_i high, regardless of inc_i/load_i.
REQ-027 After reset: pm_o=0; displayed hour 00 (24-hour) or 12 (12-hour).
REQ-028 Reset asserted mid-prescale discards the partial count; first second after release needs a full TICK_DIV inc_i pulses.

Verification
REQ-029 TICK_DIV=1, reset, 61 inc_i pulses -> 00:01:01, rollover_o never high.
REQ-030 Load 23:59:59, one inc_i -> 00:00:00, rollover_o high one cycle, pm_o 1->0.
REQ-031 TICK_DIV=4, 3 inc_i, load 10:00:00, 3 inc_i -> still 10:00:00; 4th inc_i -> 10:00:01.
REQ-032 Load hh=24 (hour_h=2, hour_l=4) from 05:06:07 with inc_i high -> time stays 05:06:07, load_err_o one-cycle pulse, no advance.
REQ-033 mode_12h_i=1, load 00:30:00, 13:45:00, 12:00:00 -> displays 12:30 pm_o=0, 01:45 pm_o=1, 12:00 pm_o=1.
REQ-034 Assert rst_i asynchronously between clock edges at 14:22:33 -> outputs 00:00:00 before next edge, remain until release.
